pipe_hazard_ctrl: RTL and testbench

- Hazard and stall controller for the 5-stage pipelined CPU; sequences the IF/ID pipeline register and the PC.
- Detects load-use hazards, multi-cycle control-transfer resolution and instruction-memory wait.
- Drives the IF/ID hold (wpcir) and flush (jwait) controls, a bubble into ID/EX, and the ID-stage forwarding selects.
- Keeps a saturating stall-cycle counter for debug.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_fwd_sel.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forwarding-select values and register-field widths.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT4_W = 4;
    localparam int unsigned FWD_W = 2;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        LU  = 2'd1,
        JW  = 2'd2
    } hz_state_e;

    localparam logic [FWD_W-1:0] FWD_RF     = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EXALU  = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEMALU = 2'd2;
    localparam logic [FWD_W-1:0] FWD_MEMLD  = 2'd3;

    // True when a producer writes a real (non-zero) register that matches src.
    function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst,
                                     input logic             wreg);
        return wreg && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// ID-stage operand forwarding select for one source register.
// EX ALU results win over MEM; EX loads are not forwardable (load-use stalls).
module pipe_fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] ex_rn_i,
    input  logic             ex_wreg_i,
    input  logic             ex_m2reg_i,
    input  logic [REG_W-1:0] mem_rn_i,
    input  logic             mem_wreg_i,
    input  logic             mem_m2reg_i,
    output logic [FWD_W-1:0] sel_o
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = reg_hit(src_i, ex_rn_i, ex_wreg_i) && !ex_m2reg_i;
    assign mem_hit = reg_hit(src_i, mem_rn_i, mem_wreg_i);

    always_comb begin
        sel_o = FWD_RF;
        if (ex_hit) begin
            sel_o = FWD_EXALU;
        end else if (mem_hit) begin
            sel_o = mem_m2reg_i ? FWD_MEMLD : FWD_MEMALU;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use stalls, control-transfer flush window,
// instruction-memory wait, ID forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LU_CYCLES    = 1,
    parameter int unsigned JWAIT_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_jmp,
    input  logic [REG_W-1:0] ex_rn,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [REG_W-1:0] mem_rn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic             imem_ready,
    output logic             wpcir,
    output logic             jwait,
    output logic             bubble,
    output logic [FWD_W-1:0] fwda,
    output logic [FWD_W-1:0] fwdb,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT4_W-1:0] LU_RELOAD = CNT4_W'(LU_CYCLES - 32'd1);
    localparam logic [CNT4_W-1:0] JW_RELOAD = CNT4_W'(JWAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    hz_state_e         state_q, state_d;
    logic [CNT4_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic match_s;
    logic match_t;
    logic lu;

    logic [FWD_W-1:0] fwda_raw;
    logic [FWD_W-1:0] fwdb_raw;

    assign match_s = id_use_rs && reg_hit(id_rs, ex_rn, 1'b1);
    assign match_t = id_use_rt && reg_hit(id_rt, ex_rn, 1'b1);
    assign lu      = ex_wreg && ex_m2reg && (match_s || match_t);

    pipe_fwd_sel u_fwd_rs (
        .src_i       (id_rs),
        .ex_rn_i     (ex_rn),
        .ex_wreg_i   (ex_wreg),
        .ex_m2reg_i  (ex_m2reg),
        .mem_rn_i    (mem_rn),
        .mem_wreg_i  (mem_wreg),
        .mem_m2reg_i (mem_m2reg),
        .sel_o       (fwda_raw)
    );

    pipe_fwd_sel u_fwd_rt (
        .src_i       (id_rt),
        .ex_rn_i     (ex_rn),
        .ex_wreg_i   (ex_wreg),
        .ex_m2reg_i  (ex_m2reg),
        .mem_rn_i    (mem_rn),
        .mem_wreg_i  (mem_wreg),
        .mem_m2reg_i (mem_m2reg),
        .sel_o       (fwdb_raw)
    );

    assign fwda = reset ? FWD_RF : fwda_raw;
    assign fwdb = reset ? FWD_RF : fwdb_raw;

    // Next-state and same-cycle pipeline controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wpcir   = 1'b0;
        jwait   = 1'b0;
        bubble  = 1'b0;

        if (reset) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (lu) begin
                        wpcir  = 1'b1;
                        bubble = 1'b1;
                        if (LU_CYCLES > 1) begin
                            state_d = LU;
                            cnt_d   = LU_RELOAD;
                        end
                    end else if (!imem_ready) begin
                        wpcir  = 1'b1;
                        bubble = 1'b1;
                    end else if (id_jmp) begin
                        state_d = JW;
                        cnt_d   = JW_RELOAD;
                    end
                end
                LU: begin
                    wpcir  = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = cnt_q - CNT4_W'(1);
                    if (cnt_q == CNT4_W'(1)) begin
                        state_d = RUN;
                    end
                end
                JW: begin
                    jwait = 1'b1;
                    cnt_d = cnt_q - CNT4_W'(1);
                    if (cnt_q == CNT4_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Debug counter of held cycles; sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (wpcir && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for the same-cycle
// hazard/forwarding logic plus hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rn, mem_rn;
    logic       id_use_rs, id_use_rt, id_jmp;
    logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, imem_ready;

    logic        a_wpcir, a_jwait, a_bubble;
    logic [1:0]  a_fwda, a_fwdb;
    logic [15:0] a_cnt;
    logic        b_wpcir, b_jwait, b_bubble;
    logic [1:0]  b_fwda, b_fwdb;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.LU_CYCLES(1), .JWAIT_CYCLES(2), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_jmp(id_jmp), .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .imem_ready(imem_ready),
        .wpcir(a_wpcir), .jwait(a_jwait), .bubble(a_bubble),
        .fwda(a_fwda), .fwdb(a_fwdb), .stall_cnt(a_cnt)
    );

    pipe_hazard_ctrl #(.LU_CYCLES(4), .JWAIT_CYCLES(1), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_jmp(id_jmp), .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .imem_ready(imem_ready),
        .wpcir(b_wpcir), .jwait(b_jwait), .bubble(b_bubble),
        .fwda(b_fwda), .fwdb(b_fwdb), .stall_cnt(b_cnt)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] ex_rn;
        logic       ex_wreg;
        logic       ex_m2reg;
        logic [4:0] mem_rn;
        logic       mem_wreg;
        logic       mem_m2reg;
        logic       imem;
        logic       exp_stall;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic neutral();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_jmp = 1'b0;
        ex_rn = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
        mem_rn = 5'd0; mem_wreg = 1'b0; mem_m2reg = 1'b0;
        imem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        neutral();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        //          rs    rt    urs   urt   ex_rn ewr   em2r  mrn   mwr   mm2r  imem  stall fa    fb
        vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0};
        vecs[2]  = '{5'd1, 5'd6, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2};
        vecs[3]  = '{5'd6, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0};
        vecs[4]  = '{5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1};
        vecs[5]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[6]  = '{5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        vecs[7]  = '{5'd1, 5'd8, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2};
        vecs[8]  = '{5'd5, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[9]  = '{5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[10] = '{5'd0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[11] = '{5'd3, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0};
        vecs[12] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};

        // Reset forces every output low even with live hazard/forward inputs.
        neutral();
        reset = 1'b1;
        id_rs = 5'd5; id_use_rs = 1'b1; ex_rn = 5'd5; ex_wreg = 1'b1;
        mem_rn = 5'd5; mem_wreg = 1'b1; id_rt = 5'd5; imem_ready = 1'b0;
        #1;
        chk("rst_wpcir", 32'(a_wpcir), 32'd0);
        chk("rst_bubble", 32'(a_bubble), 32'd0);
        chk("rst_fwda", 32'(a_fwda), 32'd0);
        chk("rst_fwdb", 32'(a_fwdb), 32'd0);
        tick();
        do_reset();
        chk("rst_cnt_a", 32'(a_cnt), 32'd0);
        chk("rst_cnt_b", 32'(b_cnt), 32'd0);

        // Same-cycle table on dut_a (LU_CYCLES=1 keeps it in RUN).
        for (int i = 0; i < 13; i++) begin
            neutral();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
            ex_rn = vecs[i].ex_rn; ex_wreg = vecs[i].ex_wreg; ex_m2reg = vecs[i].ex_m2reg;
            mem_rn = vecs[i].mem_rn; mem_wreg = vecs[i].mem_wreg; mem_m2reg = vecs[i].mem_m2reg;
            imem_ready = vecs[i].imem;
            #1;
            chk($sformatf("v%0d_wpcir", i), 32'(a_wpcir), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d_bubble", i), 32'(a_bubble), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d_jwait", i), 32'(a_jwait), 32'd0);
            chk($sformatf("v%0d_fwda", i), 32'(a_fwda), 32'(vecs[i].exp_fa));
            chk($sformatf("v%0d_fwdb", i), 32'(a_fwdb), 32'(vecs[i].exp_fb));
            tick();
        end
        chk("table_cnt_a", 32'(a_cnt), 32'd3);

        // Load-use: one stall on dut_a, four on dut_b; reset dut_b in its 2nd.
        do_reset();
        ex_rn = 5'd5; ex_wreg = 1'b1; ex_m2reg = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1;
        #1;
        chk("lu_wpcir", 32'(a_wpcir), 32'd1);
        chk("lu_bubble", 32'(a_bubble), 32'd1);
        chk("lu_b_wpcir", 32'(b_wpcir), 32'd1);
        tick();
        ex_rn = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
        mem_rn = 5'd5; mem_wreg = 1'b1; mem_m2reg = 1'b1;
        #1;
        chk("lu_next_wpcir", 32'(a_wpcir), 32'd0);
        chk("lu_next_bubble", 32'(a_bubble), 32'd0);
        chk("lu_next_fwda", 32'(a_fwda), 32'd3);
        chk("lu_a_cnt", 32'(a_cnt), 32'd1);
        chk("lu_b_hold", 32'(b_wpcir), 32'd1);
        chk("lu_b_bubble", 32'(b_bubble), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstlu_wpcir", 32'(b_wpcir), 32'd0);
        chk("rstlu_bubble", 32'(b_bubble), 32'd0);
        chk("rstlu_fwda", 32'(b_fwda), 32'd0);
        tick();
        reset = 1'b0;
        neutral();
        #1;
        chk("rstlu_run", 32'(b_wpcir), 32'd0);
        chk("rstlu_cnt", 32'(b_cnt), 32'd0);

        // Jump with imem stalled and a load-use pattern during the flush window.
        do_reset();
        id_jmp = 1'b1;
        #1;
        chk("jmp_acc_wpcir", 32'(a_wpcir), 32'd0);
        chk("jmp_acc_jwait", 32'(a_jwait), 32'd0);
        tick();
        imem_ready = 1'b0;
        ex_rn = 5'd4; ex_wreg = 1'b1; ex_m2reg = 1'b1; id_rs = 5'd4; id_use_rs = 1'b1;
        #1;
        chk("jw1_jwait", 32'(a_jwait), 32'd1);
        chk("jw1_wpcir", 32'(a_wpcir), 32'd0);
        chk("jw1_bubble", 32'(a_bubble), 32'd0);
        chk("jw1_b_jwait", 32'(b_jwait), 32'd1);
        tick();
        #1;
        chk("jw2_jwait", 32'(a_jwait), 32'd1);
        chk("jw2_wpcir", 32'(a_wpcir), 32'd0);
        neutral();
        #1;
        chk("jw2_b_jwait", 32'(b_jwait), 32'd0);
        tick();
        chk("jw_end_jwait", 32'(a_jwait), 32'd0);
        chk("jw_end_wpcir", 32'(a_wpcir), 32'd0);

        // Load-use and jump together: stall first, jump accepted next cycle.
        do_reset();
        ex_rn = 5'd6; ex_wreg = 1'b1; ex_m2reg = 1'b1; id_rt = 5'd6; id_use_rt = 1'b1;
        id_jmp = 1'b1;
        #1;
        chk("sim_wpcir", 32'(a_wpcir), 32'd1);
        chk("sim_jwait", 32'(a_jwait), 32'd0);
        tick();
        ex_rn = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
        #1;
        chk("sim_acc_wpcir", 32'(a_wpcir), 32'd0);
        chk("sim_acc_jwait", 32'(a_jwait), 32'd0);
        tick();
        id_jmp = 1'b0;
        #1;
        chk("sim_jw1", 32'(a_jwait), 32'd1);
        tick();
        chk("sim_jw2", 32'(a_jwait), 32'd1);
        tick();
        chk("sim_jw_end", 32'(a_jwait), 32'd0);

        // Counter saturation on the 4-bit instance.
        do_reset();
        imem_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
        end
        chk("sat_b_cnt", 32'(b_cnt), 32'd15);
        chk("sat_a_cnt", 32'(a_cnt), 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
